// File: rtl/adc_avg_pkg.sv
// Shared types and sizing helpers for the block-averaging ADC decimator.
package adc_avg_pkg;

   // Controller states: waiting for acquisition, or summing a block.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Width of the saturating dropped-block counter.
   localparam int DROP_CNT_W = 16;

   // Number of bits needed to express a log2 decimation from 0 to max_log2.
   function automatic int clog2_decim(input int max_log2);
      return $clog2(max_log2 + 1);
   endfunction

endpackage

// File: rtl/adc_avg_shift_round.sv
// Turns a block sum into the block mean: optional round-half-up offset, then
// an arithmetic right shift by k, truncated to the sample width.
module adc_avg_shift_round
   import adc_avg_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int MAX_LOG2_DECIM = 6,
   parameter int ROUND          = 0,
   parameter int ACC_W          = DATA_W + MAX_LOG2_DECIM,
   parameter int K_W            = clog2_decim(MAX_LOG2_DECIM)
) (
   input  logic signed [ACC_W-1:0]  i_sum,
   input  logic        [K_W-1:0]    i_k,
   output logic signed [DATA_W-1:0] o_mean
);

   // One extra bit of headroom so the rounding offset can never wrap the sum.
   function automatic logic signed [DATA_W-1:0] shift_round(
      input logic signed [ACC_W-1:0] sum,
      input logic        [K_W-1:0]   k
   );
      logic signed [ACC_W:0] v_ext;
      logic signed [ACC_W:0] v_ofs;
      logic signed [ACC_W:0] v_shift;
      v_ext = {sum[ACC_W-1], sum};
      if ((ROUND != 0) && (k != '0)) begin
         v_ofs = (ACC_W+1)'(1) << (k - K_W'(1));
      end else begin
         v_ofs = '0;
      end
      v_shift = (v_ext + v_ofs) >>> k;
      return v_shift[DATA_W-1:0];
   endfunction

   assign o_mean = shift_round(i_sum, i_k);

endmodule

// File: rtl/adc_decim_avg.sv
// Block averager for the fast ADC path: sums 2^k signed samples, emits one
// FIFO write per completed block, and counts blocks lost to a full FIFO.
module adc_decim_avg
   import adc_avg_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int MAX_LOG2_DECIM = 6,
   parameter int ROUND          = 0,
   parameter int K_W            = clog2_decim(MAX_LOG2_DECIM)
) (
   input  logic                     ADC_outclock,
   input  logic                     reset,
   input  logic                     ADC_acquire,
   input  logic signed [DATA_W-1:0] ADC_data,
   input  logic        [K_W-1:0]    decim_log2,
   input  logic                     fifo_full,
   input  logic                     clr_status,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_wrreq,
   output logic                     busy,
   output logic                     overflow,
   output logic [DROP_CNT_W-1:0]    drop_count
);

   localparam int ACC_W = DATA_W + MAX_LOG2_DECIM;
   localparam int CNT_W = MAX_LOG2_DECIM + 1;

   state_t                    r_state;
   logic signed [ACC_W-1:0]   r_acc;
   logic        [CNT_W-1:0]   r_cnt;
   logic        [K_W-1:0]     r_k_lat;
   logic signed [DATA_W-1:0]  r_out_data;
   logic                      r_out_wrreq;
   logic                      r_busy;
   logic                      r_overflow;
   logic [DROP_CNT_W-1:0]     r_drop_count;

   logic        [K_W-1:0]     w_k_req;
   logic        [K_W-1:0]     w_k_eff;
   logic signed [ACC_W-1:0]   w_sample_ext;
   logic signed [ACC_W-1:0]   w_sum;
   logic        [CNT_W-1:0]   w_cnt_next;
   logic        [CNT_W-1:0]   w_target;
   logic                      w_done;
   logic signed [DATA_W-1:0]  w_mean;

   // Requests beyond the supported range clamp to the largest block size.
   assign w_k_req      = (decim_log2 > K_W'(MAX_LOG2_DECIM)) ? K_W'(MAX_LOG2_DECIM) : decim_log2;
   // A block starting this edge uses the fresh request; otherwise the latched k.
   assign w_k_eff      = (r_state == IDLE) ? w_k_req : r_k_lat;
   assign w_sample_ext = ACC_W'(ADC_data);
   // acc and cnt are zero in IDLE, so the same adder serves the first sample.
   assign w_sum        = r_acc + w_sample_ext;
   assign w_cnt_next   = r_cnt + CNT_W'(1);
   assign w_target     = CNT_W'(1) << w_k_eff;
   assign w_done       = ADC_acquire && (w_cnt_next == w_target);

   adc_avg_shift_round #(
      .DATA_W         (DATA_W),
      .MAX_LOG2_DECIM (MAX_LOG2_DECIM),
      .ROUND          (ROUND),
      .ACC_W          (ACC_W),
      .K_W            (K_W)
   ) u_shift_round (
      .i_sum  (w_sum),
      .i_k    (w_k_eff),
      .o_mean (w_mean)
   );

   // Acquisition FSM: accumulate, complete blocks, discard partial blocks on acquire loss.
   always_ff @(posedge ADC_outclock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_k_lat     <= '0;
         r_out_data  <= '0;
         r_out_wrreq <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_out_wrreq <= 1'b0;
         if (ADC_acquire) begin
            if (r_state == IDLE) begin
               r_k_lat <= w_k_req;
            end else begin
               r_k_lat <= r_k_lat;
            end
            if (w_done) begin
               r_out_data  <= w_mean;
               r_out_wrreq <= ~fifo_full;
               r_acc       <= '0;
               r_cnt       <= '0;
               // A single-sample block started from IDLE never leaves IDLE.
               r_state     <= r_state;
               r_busy      <= (r_state == ACCUM);
            end else begin
               r_acc   <= w_sum;
               r_cnt   <= w_cnt_next;
               r_state <= ACCUM;
               r_busy  <= 1'b1;
            end
         end else begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end
      end
   end

   // Sticky drop status; a clear on the same edge as a drop wins.
   always_ff @(posedge ADC_outclock) begin
      if (reset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (clr_status) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_done && fifo_full) begin
         r_overflow <= 1'b1;
         if (r_drop_count != '1) begin
            r_drop_count <= r_drop_count + DROP_CNT_W'(1);
         end else begin
            r_drop_count <= r_drop_count;
         end
      end else begin
         r_overflow   <= r_overflow;
         r_drop_count <= r_drop_count;
      end
   end

   assign out_data   = r_out_data;
   assign out_wrreq  = r_out_wrreq;
   assign busy       = r_busy;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_adc_decim_avg.sv
// Scoreboard bench: a truncating and a rounding instance share the stimulus;
// expected means are queued when a block's last sample is driven.
module tb_adc_decim_avg;

   logic               clk = 1'b0;
   logic               reset;
   logic               acq;
   logic signed [15:0] din;
   logic [2:0]         dlog;
   logic               full;
   logic               clr;
   logic signed [15:0] od0, od1;
   logic               wr0, wr1, busy0, busy1, ovf0, ovf1;
   logic [15:0]        dc0, dc1;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   // model state
   bit      m_active;
   int      m_k;
   longint  m_sum;
   int      m_cnt;
   bit      m_ovf;
   int      m_drops;

   always #5 clk = ~clk;

   adc_decim_avg #(.DATA_W(16), .MAX_LOG2_DECIM(6), .ROUND(0)) dut0 (
      .ADC_outclock(clk), .reset(reset), .ADC_acquire(acq), .ADC_data(din),
      .decim_log2(dlog), .fifo_full(full), .clr_status(clr),
      .out_data(od0), .out_wrreq(wr0), .busy(busy0), .overflow(ovf0), .drop_count(dc0));

   adc_decim_avg #(.DATA_W(16), .MAX_LOG2_DECIM(6), .ROUND(1)) dut1 (
      .ADC_outclock(clk), .reset(reset), .ADC_acquire(acq), .ADC_data(din),
      .decim_log2(dlog), .fifo_full(full), .clr_status(clr),
      .out_data(od1), .out_wrreq(wr1), .busy(busy1), .overflow(ovf1), .drop_count(dc1));

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mean(input longint s, input int k, input bit rnd);
      longint t;
      t = s;
      if (rnd && k > 0) t = t + (longint'(1) << (k - 1));
      t = t >>> k;
      return t[15:0];
   endfunction

   task automatic check_status();
      chk("busy0", int'(busy0), int'(m_active));
      chk("busy1", int'(busy1), int'(m_active));
      chk("ovf0",  int'(ovf0),  int'(m_ovf));
      chk("ovf1",  int'(ovf1),  int'(m_ovf));
      chk("drops0", int'(dc0),  m_drops);
      chk("drops1", int'(dc1),  m_drops);
   endtask

   // One sample clock: drive at negedge, update the model, check status after the edge.
   task automatic step(input bit a, input int d, input int k, input bit f, input bit c);
      bit done;
      @(negedge clk);
      acq  = a;
      din  = 16'(d);
      dlog = 3'(k);
      full = f;
      clr  = c;
      done = 1'b0;
      if (a) begin
         if (!m_active) begin
            m_k = (k > 6) ? 6 : k;
            m_sum = 0;
            m_cnt = 0;
            m_active = 1'b1;
         end
         m_sum = m_sum + longint'(d);
         m_cnt++;
         if (m_cnt == (1 << m_k)) begin
            done = 1'b1;
            if (!f) begin
               q0.push_back(mean(m_sum, m_k, 1'b0));
               q1.push_back(mean(m_sum, m_k, 1'b1));
            end
            m_sum = 0;
            m_cnt = 0;
            if (m_k == 0) m_active = 1'b0;
         end
      end else begin
         m_active = 1'b0;
         m_sum = 0;
         m_cnt = 0;
      end
      if (c) begin
         m_ovf = 1'b0;
         m_drops = 0;
      end else if (done && f) begin
         m_ovf = 1'b1;
         if (m_drops < 65535) m_drops++;
      end
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      acq = 1'b0;
      clr = 1'b0;
      full = 1'b0;
      @(posedge clk);
      #1;
      m_active = 1'b0; m_sum = 0; m_cnt = 0; m_ovf = 1'b0; m_drops = 0; m_k = 0;
      chk("rst_od0", int'(od0), 0);
      chk("rst_od1", int'(od1), 0);
      chk("rst_wr0", int'(wr0), 0);
      check_status();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Output monitor: every write strobe must match the next queued mean.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr0) begin
            if (q0.size() == 0) chk("wr0_spurious", 1, 0);
            else chk("out0", int'(od0), int'(signed'(q0.pop_front())));
         end
         if (wr1) begin
            if (q1.size() == 0) chk("wr1_spurious", 1, 0);
            else chk("out1", int'(od1), int'(signed'(q1.pop_front())));
         end
      end
   end

   initial begin
      reset = 1'b1; acq = 1'b0; din = '0; dlog = '0; full = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // 1: k=1, 100,-3 pairs -> 48
      for (int i = 0; i < 3; i++) begin
         step(1, 100, 1, 0, 0);
         step(1, -3, 1, 0, 0);
         chk("t1_const", int'(od0), 48);
      end
      step(0, 0, 1, 0, 0);

      // 2: k=2 rounding
      step(1, 1, 2, 0, 0); step(1, 1, 2, 0, 0); step(1, 1, 2, 0, 0); step(1, 0, 2, 0, 0);
      chk("t2_trunc", int'(od0), 0);
      chk("t2_round", int'(od1), 1);
      step(1, -1, 2, 0, 0); step(1, -1, 2, 0, 0); step(1, -1, 2, 0, 0); step(1, -2, 2, 0, 0);
      chk("t2_neg_trunc", int'(od0), -2);
      chk("t2_neg_round", int'(od1), -1);
      step(0, 0, 2, 0, 0);

      // 3: k=0 passthrough
      for (int i = 7; i <= 11; i++) begin
         step(1, i, 0, 0, 0);
         chk("t3_pass", int'(od0), i);
      end
      step(0, 0, 0, 0, 0);

      // 4: aborted partial block, then one full block of 16s
      for (int i = 0; i < 5; i++) step(1, 1000, 3, 0, 0);
      step(0, 0, 3, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 16, 3, 0, 0);
      chk("t4_const", int'(od0), 16);
      step(0, 0, 3, 0, 0);

      // 5: backpressure and status clear
      for (int i = 0; i < 6; i++) step(1, 50 + i, 1, 1, 0);
      chk("t5_drops", int'(dc0), 3);
      chk("t5_ovf", int'(ovf0), 1);
      step(0, 0, 1, 0, 1);
      step(1, 5, 1, 1, 0);
      step(1, 6, 1, 1, 1);
      chk("t5_clr_wins", int'(dc0), 0);
      step(0, 0, 1, 0, 0);

      // 6: clamp 7 -> 64-sample block, mid-block k change ignored
      for (int i = 0; i < 64; i++) step(1, int'($urandom_range(0, 65535)) - 32768, (i < 20) ? 7 : 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 200 + i, 2, 0, 0);
      do_reset();
      step(0, 0, 2, 0, 0);
      step(0, 0, 2, 0, 0);

      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
